// File: rtl/gradient_gen_if.sv
// gradient_gen_if: pixel stream in, signed gradient stream out
interface gradient_gen_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_valid;
  logic [DATA_WIDTH:0]   gx;
  logic [DATA_WIDTH:0]   gy;
  logic                  grad_valid;
  logic                  grad_last;
  modport master (output pixel_in, pixel_valid, input gx, gy, grad_valid, grad_last);
  modport slave  (input pixel_in, pixel_valid, output gx, gy, grad_valid, grad_last);
endinterface

// File: rtl/gradient_gen.sv
// gradient_gen: raster pixel stream to central-difference gx/gy for interior pixels
module gradient_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48
) (
  input  logic           clk,
  input  logic           rst,
  gradient_gen_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = DATA_WIDTH + 1;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
  // column c-1 of the window (rows r-2, r-1, r) and the centre row of column c-2;
  // the corners of column c-2 never enter either difference, so they are not kept
  logic [DATA_WIDTH-1:0] w1_top_q, w1_mid_q, w1_bot_q, w2_mid_q;
  logic [GW-1:0]         gx_q, gy_q, gx_d, gy_d;
  logic                  valid_q, last_q;
  logic                  wrap_c, wrap_r, fire;
  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];
  // position bookkeeping and the differences for the window completed by this pixel
  always_comb begin
    wrap_c = col_q == CW'(IMG_WIDTH - 1);
    wrap_r = row_q == RW'(IMG_HEIGHT - 1);
    col_d  = !bus.pixel_valid ? col_q : wrap_c ? '0 : col_q + 1'b1;
    row_d  = !(bus.pixel_valid && wrap_c) ? row_q : wrap_r ? '0 : row_q + 1'b1;
    fire   = bus.pixel_valid && row_q >= RW'(2) && col_q >= CW'(2);
    gx_d   = {1'b0, lb1_rd} - {1'b0, w2_mid_q};
    gy_d   = {1'b0, w1_bot_q} - {1'b0, w1_top_q};
  end
  // counters and registered outputs; gradients hold while no window completes
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= fire;
      last_q  <= fire && wrap_c && wrap_r;
      if (fire) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
    end
  end
  // line buffers read-before-write at column c, window shifts one column per pixel
  always_ff @(posedge clk) begin
    if (bus.pixel_valid && !rst) begin
      lb2_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= bus.pixel_in;
      w1_top_q     <= lb2_rd;
      w1_mid_q     <= lb1_rd;
      w1_bot_q     <= bus.pixel_in;
      w2_mid_q     <= w1_mid_q;
    end
  end
  assign bus.gx         = gx_q;
  assign bus.gy         = gy_q;
  assign bus.grad_valid = valid_q;
  assign bus.grad_last  = last_q;
endmodule

// File: tb/tb_gradient_gen.sv
// tb_gradient_gen: directed frames on an 8x6 image checked cycle by cycle
module tb_gradient_gen;
  localparam int W = 8;
  localparam int H = 6;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int nout, nlast;
  logic [7:0] img [H][W];
  logic [8:0] gx_seen [H][W];
  logic [8:0] gy_seen [H][W];
  logic [8:0] hold_gx, hold_gy;
  gradient_gen_if #(.DATA_WIDTH(8)) bus ();
  gradient_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic set_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0: img[r][c] = 8'(4 * c);
          1: img[r][c] = 8'(10 * r);
          2: img[r][c] = c < 4 ? 8'd255 : 8'd0;
          3: img[r][c] = c < 4 ? 8'd0 : 8'd255;
          default: img[r][c] = 8'($urandom);
        endcase
  endtask
  task automatic push(input int r, input int c);
    logic ev;
    bus.pixel_in = img[r][c];
    bus.pixel_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    ev = r >= 2 && c >= 2;
    if (ev) begin
      hold_gx = {1'b0, img[r-1][c]} - {1'b0, img[r-1][c-2]};
      hold_gy = {1'b0, img[r][c-1]} - {1'b0, img[r-2][c-1]};
    end
    chk("grad_valid", bus.grad_valid, ev);
    chk("grad_last", bus.grad_last, ev && r == H - 1 && c == W - 1);
    chk("gx", bus.gx, hold_gx);
    chk("gy", bus.gy, hold_gy);
    if (bus.grad_valid) nout++;
    if (bus.grad_last) nlast++;
    gx_seen[r][c] = bus.gx;
    gy_seen[r][c] = bus.gy;
  endtask
  task automatic bubble();
    bus.pixel_in = 8'($urandom);
    bus.pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bubble_valid", bus.grad_valid, 1'b0);
    chk("bubble_last", bus.grad_last, 1'b0);
    chk("bubble_gx_hold", bus.gx, hold_gx);
    chk("bubble_gy_hold", bus.gy, hold_gy);
  endtask
  task automatic run_frame(input bit bubbles);
    nout = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (bubbles)
          while ($urandom_range(0, 2) == 0) bubble();
        push(r, c);
      end
    chk("frame_count", nout, (W - 2) * (H - 2));
  endtask
  initial begin
    rst = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.pixel_in = 8'hAA;
    hold_gx = '0;
    hold_gy = '0;
    nlast = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", bus.grad_valid, 1'b0);
    chk("reset_last", bus.grad_last, 1'b0);
    chk("reset_gx", bus.gx, 9'd0);
    chk("reset_gy", bus.gy, 9'd0);
    rst = 1'b0;
    bus.pixel_valid = 1'b0;
    set_img(0);
    run_frame(0);
    chk("colramp_gx", gx_seen[3][4], 9'd8);
    chk("colramp_gy", gy_seen[3][4], 9'd0);
    set_img(1);
    run_frame(0);
    chk("rowramp_gx", gx_seen[4][6], 9'd0);
    chk("rowramp_gy", gy_seen[4][6], 9'd20);
    set_img(2);
    run_frame(0);
    chk("extreme_neg", gx_seen[2][5], 9'h101);
    set_img(3);
    run_frame(0);
    chk("extreme_pos", gx_seen[2][4], 9'h0FF);
    set_img(4);
    run_frame(1);
    set_img(4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c < 3 * W + 5) push(r, c);
    rst = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.pixel_in = img[3][5];
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.pixel_valid = 1'b0;
    hold_gx = '0;
    hold_gy = '0;
    chk("midrst_valid", bus.grad_valid, 1'b0);
    chk("midrst_gx", bus.gx, 9'd0);
    chk("midrst_gy", bus.gy, 9'd0);
    set_img(4);
    run_frame(0);
    nlast = 0;
    set_img(4);
    run_frame(0);
    set_img(4);
    run_frame(0);
    chk("two_frame_last", nlast, 2);
    bubble();
    bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gradient_gen.md
# gradient_gen

Streaming pixel-to-gradient producer for the HOG pipeline. It accepts a raster-order grayscale pixel stream and emits signed central-difference gradients gx and gy, DATA_WIDTH+1 bits each, for every interior pixel of the frame. Its output is the exact signed input format consumed by `abs`. It sits between the camera/pixel source and `abs`, and owns the line buffering and frame bookkeeping.

## Interface
- DATA_WIDTH, 8, unsigned pixel width; gradients are DATA_WIDTH+1 bits two's complement.
- IMG_WIDTH, 64, pixels per line (≥3).
- IMG_HEIGHT, 48, lines per frame (≥3).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_in  in  DATA_WIDTH  unsigned pixel, raster order (row-major, top-left first).
- pixel_valid  in  1  pixel_in is valid this cycle; there is no backpressure.
- gx  out  DATA_WIDTH+1  signed horizontal gradient.
- gy  out  DATA_WIDTH+1  signed vertical gradient.
- grad_valid  out  1  gx/gy valid this cycle (single-cycle qualifier).
- grad_last  out  1  high with the final grad_valid of a frame.

## Operation
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on pixel_valid.
  - col wraps to 0 after IMG_WIDTH-1, and row then increments.
  - row wraps to 0 after IMG_HEIGHT-1, and the next pixel starts a new frame.
- Two line buffers, each IMG_WIDTH × DATA_WIDTH:
  - LB1 holds row r-1.
  - LB2 holds row r-2.
  - On each accepted pixel at column c: LB2[c] ← LB1[c], LB1[c] ← pixel_in.
- A 3×3 window is kept as three column shift registers fed from {LB2[c], LB1[c], pixel_in}.
- When pixel (r,c) is accepted with r≥2 and c≥2, the window centre is P(r-1,c-1). Then:
  - gx = P(r-1,c) − P(r-1,c-2)
  - gy = P(r,c-1) − P(r-2,c-1)
- Arithmetic: zero-extend both operands to DATA_WIDTH+1 bits, then subtract. The result range is −(2^DATA_WIDTH−1)..+(2^DATA_WIDTH−1), so it never overflows. There is no saturation.
- Gradients for border pixels (row 0, row H-1, col 0, col W-1) are not produced.
- Output count per frame is exactly (IMG_WIDTH−2)·(IMG_HEIGHT−2).
- Window state never spans a line boundary: columns c<2 of each line produce no output, even though the shift registers still hold data from the previous line.
- Frame boundary: the line buffers are not cleared. Rows 0–1 of a new frame produce no output, so stale data is never used.
- No internal state machine beyond the counters. The pipeline is stall-transparent: with pixel_valid low, all state holds and grad_valid is 0.

## Timing
- Reset values: gx=0, gy=0, grad_valid=0, grad_last=0, col=0, row=0. Line buffer contents are don't-care.
- Latency: gx/gy/grad_valid are registered one cycle after the accepting edge of the completing pixel (r,c), i.e. valid in cycle N+1 when pixel_valid is high in cycle N.
- grad_valid is high for exactly one cycle per qualifying pixel. Back-to-back pixels give back-to-back outputs.
- gx/gy hold their last value while grad_valid is low.
- grad_last is asserted with the output generated by pixel (IMG_HEIGHT−1, IMG_WIDTH−1).
- rst mid-frame:
  - takes effect at the next edge;
  - the output registered that cycle is dropped (grad_valid=0);
  - counters return to 0, so the next valid pixel is (0,0) of a new frame;
  - no output appears until row 2, col 2 of that frame.
- pixel_valid during rst is ignored.
- Line buffers use one write and one read per accepted pixel, both at address c. A read-before-write RAM is required.

## Test plan
- Column ramp, W=8, H=6, P=4·col, continuous valid → 24 outputs, all gx=+8, gy=0. grad_last is high only on the 24th output.
- Row ramp, P=10·row → all gx=0, gy=+20. The first grad_valid arrives exactly 1 cycle after pixel (2,2) is accepted.
- Extremes: col 0–3 = 255, rest = 0 → at centre col 4, gx = 0−255 = −255 (9'h101). At centre col 3 of a mirrored pattern, gx=+255. No wrap errors.
- Random bubbles: pixel_valid toggled pseudo-randomly on a random image → output sequence identical to a golden model ignoring bubbles. grad_valid is never high 2 cycles after a bubble unless a new pixel completes a window.
- Reset at pixel (3,5) of frame 1, then a fresh frame → no outputs until the new frame's (2,2). Then exactly 24 correct outputs, with no stale-line contamination.
- Two consecutive frames, distinct content, no gap → 48 outputs. grad_last fires twice, and frame-2 values match the golden model.
